// File: rtl/bcd_demux.sv
// bcd_demux: rebuilds a parallel BCD word from a time-multiplexed digit bus and its one-hot select
module bcd_demux #(
    parameter int DISPLAYS_NUM    = 4,
    parameter int MIN_STABLE_CLKS = 3,
    parameter int TIMEOUT_CLKS    = 256
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [3:0]                i_bcd_muxed,
    input  logic [DISPLAYS_NUM-1:0]   i_bcd_sel,
    output logic [4*DISPLAYS_NUM-1:0] o_bcd_data,
    output logic                      o_frame_valid,
    output logic                      o_locked,
    output logic                      o_err_onehot,
    output logic                      o_err_digit,
    output logic                      o_err_order,
    output logic                      o_timeout
);
    localparam int N  = DISPLAYS_NUM;
    localparam int EW = N > 1 ? $clog2(N) : 1;
    // one extra count above the threshold lets a long dwell saturate without re-accepting
    localparam int CW = $clog2(MIN_STABLE_CLKS + 2);
    localparam int TW = TIMEOUT_CLKS > 1 ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [EW-1:0] E_LAST = EW'(N - 1);
    localparam logic [CW-1:0] C_MIN  = CW'(MIN_STABLE_CLKS);
    localparam logic [CW-1:0] C_SAT  = CW'(MIN_STABLE_CLKS + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic {HUNT, CAPT} state_t;

    logic [N-1:0]   in_sel_q, sel_q, exp_sel;
    logic [3:0]     in_dig_q, dig_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           acc, onehot, bad_dig;
    state_t         state_q, state_d;
    logic [EW-1:0]  e_q, e_d;
    logic [4*N-1:0] sh_q, sh_d, data_q, data_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic           fv_q, fv_d, eoh_q, eoh_d, edig_q, edig_d, eord_q, eord_d, to_q, to_d;

    // the counter describes how long the pair in sel_q/dig_q has been stable
    assign cnt_d   = (in_sel_q == sel_q && in_dig_q == dig_q) ?
                     ((cnt_q == C_SAT) ? C_SAT : cnt_q + 1'b1) : CW'(1);
    assign acc     = cnt_q == C_MIN && sel_q != '0;
    assign onehot  = (sel_q & (sel_q - 1'b1)) == '0;
    assign bad_dig = dig_q > 4'd9;

    // input register followed by the stability-filter stage
    always_ff @(posedge i_clk or negedge i_rst)
        if (!i_rst) begin
            in_sel_q <= '0;
            in_dig_q <= '0;
            sel_q    <= '0;
            dig_q    <= '0;
            cnt_q    <= '0;
        end else begin
            in_sel_q <= i_bcd_sel;
            in_dig_q <= i_bcd_muxed;
            sel_q    <= in_sel_q;
            dig_q    <= in_dig_q;
            cnt_q    <= cnt_d;
        end

    // scan sequencing, shadow assembly, error and timeout decisions
    always_comb begin
        state_d = state_q;
        e_d     = e_q;
        sh_d    = sh_q;
        tcnt_d  = tcnt_q + 1'b1;
        data_d  = data_q;
        fv_d    = 1'b0;
        eoh_d   = 1'b0;
        edig_d  = 1'b0;
        eord_d  = 1'b0;
        to_d    = 1'b0;
        exp_sel = '0;
        exp_sel[e_q] = 1'b1;
        if (acc) begin
            tcnt_d = '0;
            if (!onehot) begin
                eoh_d   = 1'b1;
                state_d = HUNT;
                e_d     = '0;
                sh_d    = '0;
            end else if (state_q == CAPT && sel_q == exp_sel) begin
                sh_d[4*(N-1-int'(e_q)) +: 4] = dig_q;
                edig_d = bad_dig;
                if (e_q == E_LAST) begin
                    data_d = sh_d;
                    fv_d   = 1'b1;
                    e_d    = '0;
                    sh_d   = '0;
                end else
                    e_d = e_q + 1'b1;
            end else if (sel_q[0]) begin
                eord_d  = state_q == CAPT;
                edig_d  = bad_dig && state_q == HUNT;
                sh_d    = '0;
                sh_d[4*N-1 -: 4] = dig_q;
                state_d = CAPT;
                if (N == 1) begin
                    data_d = sh_d;
                    fv_d   = 1'b1;
                    e_d    = '0;
                    sh_d   = '0;
                end else
                    e_d = EW'(1);
            end else if (state_q == CAPT) begin
                eord_d  = 1'b1;
                state_d = HUNT;
                e_d     = '0;
                sh_d    = '0;
            end
        end else if (tcnt_q == T_LAST) begin
            to_d    = 1'b1;
            state_d = HUNT;
            e_d     = '0;
            sh_d    = '0;
            tcnt_d  = '0;
        end
    end

    // state, shadow and registered outputs
    always_ff @(posedge i_clk or negedge i_rst)
        if (!i_rst) begin
            state_q <= HUNT;
            e_q     <= '0;
            sh_q    <= '0;
            tcnt_q  <= '0;
            data_q  <= '0;
            fv_q    <= 1'b0;
            eoh_q   <= 1'b0;
            edig_q  <= 1'b0;
            eord_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            sh_q    <= sh_d;
            tcnt_q  <= tcnt_d;
            data_q  <= data_d;
            fv_q    <= fv_d;
            eoh_q   <= eoh_d;
            edig_q  <= edig_d;
            eord_q  <= eord_d;
            to_q    <= to_d;
        end

    assign o_bcd_data    = data_q;
    assign o_frame_valid = fv_q;
    assign o_locked      = state_q == CAPT;
    assign o_err_onehot  = eoh_q;
    assign o_err_digit   = edig_q;
    assign o_err_order   = eord_q;
    assign o_timeout     = to_q;
endmodule
